// File: rtl/mem_init_pkg.sv
// Shared definitions for the memory-port initiator: FSM states and tag constants.
package mem_init_pkg;

  localparam int TAG_W = 7;
  localparam logic [TAG_W-1:0] TAG_RESERVED = 7'd0;
  localparam logic [TAG_W-1:0] TAG_FIRST    = 7'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Successor tag; the reserved tag is skipped so the sequence wraps 127 -> 1.
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] tag);
    logic [TAG_W-1:0] nxt;
    nxt = tag + 1'b1;
    if (nxt == TAG_RESERVED) nxt = TAG_FIRST;
    return nxt;
  endfunction

endpackage

// File: rtl/mem_tag_ctr.sv
// Wrapping request-tag counter; starts at TAG_FIRST and never produces TAG_RESERVED.
module mem_tag_ctr
  import mem_init_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [TAG_W-1:0] tag
);

  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] tag_d;

  always_comb begin
    tag_d = tag_q;
    if (advance) tag_d = next_tag(tag_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) tag_q <= TAG_FIRST;
    else      tag_q <= tag_d;
  end

  assign tag = tag_q;

endmodule

// File: rtl/mem_req_initiator.sv
// Single-outstanding requester for the unified memory port (global memory / LDS).
// Optional WAIT-state timeout is enabled by defining MEM_INIT_TIMEOUT_EN.
module mem_req_initiator
  import mem_init_pkg::*;
#(
  parameter int LANES          = 64,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_gm_or_lds,
  input  logic [3:0]              req_rd_en,
  input  logic [3:0]              req_wr_en,
  input  logic [LANES-1:0]        req_wr_mask,
  input  logic [LANES*ADDR_W-1:0] req_addr,
  input  logic [LANES*DATA_W-1:0] req_wr_data,
  output logic                    mem_gm_or_lds,
  output logic [3:0]              mem_rd_en,
  output logic [3:0]              mem_wr_en,
  output logic [LANES*ADDR_W-1:0] mem_addresses,
  output logic [LANES*DATA_W-1:0] mem_wr_data,
  output logic [LANES-1:0]        mem_wr_mask,
  output logic [TAG_W-1:0]        mem_input_tag,
  input  logic                    mem_ack,
  input  logic [TAG_W-1:0]        mem_output_tag,
  input  logic [LANES*DATA_W-1:0] mem_rd_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [TAG_W-1:0]        resp_tag,
  output logic [LANES*DATA_W-1:0] resp_data,
  output logic                    resp_err,
  output logic                    err_tag_mismatch
);

  state_e                    state_q, state_d;
  logic                      req_ready_q, req_ready_d;
  logic                      is_read_q, is_read_d;
  logic                      mem_gm_or_lds_q, mem_gm_or_lds_d;
  logic [3:0]                mem_rd_en_q, mem_rd_en_d;
  logic [3:0]                mem_wr_en_q, mem_wr_en_d;
  logic [LANES*ADDR_W-1:0]   mem_addresses_q, mem_addresses_d;
  logic [LANES*DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic [LANES-1:0]          mem_wr_mask_q, mem_wr_mask_d;
  logic [TAG_W-1:0]          mem_input_tag_q, mem_input_tag_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [TAG_W-1:0]          resp_tag_q, resp_tag_d;
  logic [LANES*DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                      resp_err_q, resp_err_d;
  logic                      err_tag_mismatch_q, err_tag_mismatch_d;
  logic [TAG_W-1:0]          cur_tag;
  logic                      tag_adv;
  logic                      ack_match;

`ifdef MEM_INIT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  mem_tag_ctr u_tag_ctr (
    .clk     (clk),
    .rst     (rst),
    .advance (tag_adv),
    .tag     (cur_tag)
  );

  assign ack_match = mem_ack && (mem_output_tag == cur_tag);

  always_comb begin
    state_d            = state_q;
    req_ready_d        = req_ready_q;
    is_read_d          = is_read_q;
    mem_gm_or_lds_d    = mem_gm_or_lds_q;
    mem_rd_en_d        = mem_rd_en_q;
    mem_wr_en_d        = mem_wr_en_q;
    mem_addresses_d    = mem_addresses_q;
    mem_wr_data_d      = mem_wr_data_q;
    mem_wr_mask_d      = mem_wr_mask_q;
    mem_input_tag_d    = mem_input_tag_q;
    resp_valid_d       = resp_valid_q;
    resp_tag_d         = resp_tag_q;
    resp_data_d        = resp_data_q;
    resp_err_d         = resp_err_q;
    err_tag_mismatch_d = err_tag_mismatch_q;
    tag_adv            = 1'b0;
`ifdef MEM_INIT_TIMEOUT_EN
    wait_cnt_d         = wait_cnt_q;
`endif

    // Any ack other than the one closing the outstanding request is stray.
    if (mem_ack && !(state_q == ST_WAIT && ack_match)) err_tag_mismatch_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if ((|req_rd_en) && (|req_wr_en)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_tag_d   = cur_tag;
            resp_data_d  = '0;
          end else begin
            state_d         = ST_ISSUE;
            is_read_d       = |req_rd_en;
            mem_gm_or_lds_d = req_gm_or_lds;
            mem_rd_en_d     = req_rd_en;
            mem_wr_en_d     = req_wr_en;
            mem_addresses_d = req_addr;
            mem_wr_data_d   = req_wr_data;
            mem_wr_mask_d   = req_wr_mask;
            mem_input_tag_d = cur_tag;
          end
        end
      end
      ST_ISSUE: begin
        state_d     = ST_WAIT;
        mem_rd_en_d = 4'd0;
        mem_wr_en_d = 4'd0;
`ifdef MEM_INIT_TIMEOUT_EN
        wait_cnt_d  = '0;
`endif
      end
      ST_WAIT: begin
        if (ack_match) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_tag_d   = cur_tag;
          resp_data_d  = is_read_q ? mem_rd_data : '0;
        end
`ifdef MEM_INIT_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_tag_d   = cur_tag;
          resp_data_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          tag_adv      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q            <= ST_IDLE;
      req_ready_q        <= 1'b0;
      is_read_q          <= 1'b0;
      mem_gm_or_lds_q    <= 1'b0;
      mem_rd_en_q        <= 4'd0;
      mem_wr_en_q        <= 4'd0;
      mem_addresses_q    <= '0;
      mem_wr_data_q      <= '0;
      mem_wr_mask_q      <= '0;
      mem_input_tag_q    <= '0;
      resp_valid_q       <= 1'b0;
      resp_tag_q         <= '0;
      resp_data_q        <= '0;
      resp_err_q         <= 1'b0;
      err_tag_mismatch_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      req_ready_q        <= (state_d == ST_IDLE) ? 1'b1 : req_ready_d;
      is_read_q          <= is_read_d;
      mem_gm_or_lds_q    <= mem_gm_or_lds_d;
      mem_rd_en_q        <= mem_rd_en_d;
      mem_wr_en_q        <= mem_wr_en_d;
      mem_addresses_q    <= mem_addresses_d;
      mem_wr_data_q      <= mem_wr_data_d;
      mem_wr_mask_q      <= mem_wr_mask_d;
      mem_input_tag_q    <= mem_input_tag_d;
      resp_valid_q       <= resp_valid_d;
      resp_tag_q         <= resp_tag_d;
      resp_data_q        <= resp_data_d;
      resp_err_q         <= resp_err_d;
      err_tag_mismatch_q <= err_tag_mismatch_d;
    end
  end

`ifdef MEM_INIT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign req_ready        = req_ready_q;
  assign mem_gm_or_lds    = mem_gm_or_lds_q;
  assign mem_rd_en        = mem_rd_en_q;
  assign mem_wr_en        = mem_wr_en_q;
  assign mem_addresses    = mem_addresses_q;
  assign mem_wr_data      = mem_wr_data_q;
  assign mem_wr_mask      = mem_wr_mask_q;
  assign mem_input_tag    = mem_input_tag_q;
  assign resp_valid       = resp_valid_q;
  assign resp_tag         = resp_tag_q;
  assign resp_data        = resp_data_q;
  assign resp_err         = resp_err_q;
  assign err_tag_mismatch = err_tag_mismatch_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator with a 4-lane configuration.
module tb_mem_req_initiator;

  localparam int LANES  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int W      = 512;

  logic                    clk;
  logic                    rst;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_gm_or_lds;
  logic [3:0]              req_rd_en;
  logic [3:0]              req_wr_en;
  logic [LANES-1:0]        req_wr_mask;
  logic [LANES*ADDR_W-1:0] req_addr;
  logic [LANES*DATA_W-1:0] req_wr_data;
  logic                    mem_gm_or_lds;
  logic [3:0]              mem_rd_en;
  logic [3:0]              mem_wr_en;
  logic [LANES*ADDR_W-1:0] mem_addresses;
  logic [LANES*DATA_W-1:0] mem_wr_data;
  logic [LANES-1:0]        mem_wr_mask;
  logic [6:0]              mem_input_tag;
  logic                    mem_ack;
  logic [6:0]              mem_output_tag;
  logic [LANES*DATA_W-1:0] mem_rd_data;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [6:0]              resp_tag;
  logic [LANES*DATA_W-1:0] resp_data;
  logic                    resp_err;
  logic                    err_tag_mismatch;

  int n_checks;
  int n_errors;

  mem_req_initiator #(
    .LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_gm_or_lds(req_gm_or_lds), .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
    .req_wr_mask(req_wr_mask), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .mem_gm_or_lds(mem_gm_or_lds), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addresses(mem_addresses), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .mem_input_tag(mem_input_tag), .mem_ack(mem_ack), .mem_output_tag(mem_output_tag),
    .mem_rd_data(mem_rd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_data(resp_data), .resp_err(resp_err), .err_tag_mismatch(err_tag_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  localparam logic [127:0] ADDRS   = {32'h34, 32'h24, 32'h14, 32'h04};
  localparam logic [127:0] LANE0_D = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_0004;

  logic [6:0] exp_tag;

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0; req_valid = 1'b0; req_gm_or_lds = 1'b0; req_rd_en = 4'd0; req_wr_en = 4'd0;
    req_wr_mask = '0; req_addr = '0; req_wr_data = '0; mem_ack = 1'b0; mem_output_tag = '0;
    mem_rd_data = '0; resp_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", W'(req_ready), W'(1'b0));
    chk("rst_mem_wr_en", W'(mem_wr_en), W'(4'd0));
    chk("rst_mem_tag", W'(mem_input_tag), W'(7'd0));
    chk("rst_resp_valid", W'(resp_valid), W'(1'b0));
    chk("rst_err", W'(err_tag_mismatch), W'(1'b0));
    rst = 1'b1;
    tick();
    chk("idle_req_ready", W'(req_ready), W'(1'b1));

    // Write, ack three cycles after acceptance.
    req_gm_or_lds = 1'b1; req_wr_en = 4'b0101; req_wr_mask = 4'h7; req_addr = ADDRS;
    req_wr_data = {4{128'h1111_2222_3333_4444_5555_6666_7777_8888}};
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("wr_issue_en", W'(mem_wr_en), W'(4'b0101));
    chk("wr_issue_rd_en", W'(mem_rd_en), W'(4'd0));
    chk("wr_issue_tag", W'(mem_input_tag), W'(7'd1));
    chk("wr_issue_addr", W'(mem_addresses), W'(ADDRS));
    chk("wr_issue_gm", W'(mem_gm_or_lds), W'(1'b1));
    chk("wr_issue_mask", W'(mem_wr_mask), W'(4'h7));
    chk("wr_issue_ready", W'(req_ready), W'(1'b0));
    tick();
    chk("wr_wait_en", W'(mem_wr_en), W'(4'd0));
    chk("wr_wait_addr", W'(mem_addresses), W'(ADDRS));
    tick();
    chk("wr_wait2_en", W'(mem_wr_en), W'(4'd0));
    mem_ack = 1'b1; mem_output_tag = 7'd1;
    tick();
    mem_ack = 1'b0;
    chk("wr_resp_valid", W'(resp_valid), W'(1'b1));
    chk("wr_resp_tag", W'(resp_tag), W'(7'd1));
    chk("wr_resp_data", resp_data, W'(0));
    chk("wr_resp_err", W'(resp_err), W'(1'b0));
    tick();
    chk("wr_resp_hold", W'(resp_valid), W'(1'b1));
    chk("wr_resp_tag_hold", W'(resp_tag), W'(7'd1));
    finish_resp();
    chk("wr_done_valid", W'(resp_valid), W'(1'b0));
    chk("wr_done_ready", W'(req_ready), W'(1'b1));

    // Read with minimum-latency ack.
    req_wr_en = 4'd0; req_rd_en = 4'b0101; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rd_issue_en", W'(mem_rd_en), W'(4'b0101));
    chk("rd_issue_tag", W'(mem_input_tag), W'(7'd2));
    tick();
    mem_ack = 1'b1; mem_output_tag = 7'd2;
    mem_rd_data = {128'h3, 128'h2, 128'h1, LANE0_D};
    tick();
    mem_ack = 1'b0;
    chk("rd_resp_valid", W'(resp_valid), W'(1'b1));
    chk("rd_resp_tag", W'(resp_tag), W'(7'd2));
    chk("rd_resp_lane0", W'(resp_data[127:0]), W'(LANE0_D));
    chk("rd_resp_all", resp_data, {128'h3, 128'h2, 128'h1, LANE0_D});
    finish_resp();

    // Wrong-tag ack while tag 3 is outstanding.
    req_rd_en = 4'd0; req_wr_en = 4'b0001; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("mm_issue_tag", W'(mem_input_tag), W'(7'd3));
    tick();
    mem_ack = 1'b1; mem_output_tag = 7'd5;
    tick();
    mem_ack = 1'b0;
    chk("mm_flag", W'(err_tag_mismatch), W'(1'b1));
    chk("mm_still_wait", W'(resp_valid), W'(1'b0));
    mem_ack = 1'b1; mem_output_tag = 7'd3;
    tick();
    mem_ack = 1'b0;
    chk("mm_resp_valid", W'(resp_valid), W'(1'b1));
    chk("mm_resp_tag", W'(resp_tag), W'(7'd3));
    chk("mm_resp_err", W'(resp_err), W'(1'b0));
    finish_resp();

    // Illegal request: both enables set.
    req_rd_en = 4'b0001; req_wr_en = 4'b0010; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("ill_resp_valid", W'(resp_valid), W'(1'b1));
    chk("ill_resp_err", W'(resp_err), W'(1'b1));
    chk("ill_resp_tag", W'(resp_tag), W'(7'd4));
    chk("ill_resp_data", resp_data, W'(0));
    chk("ill_no_rd", W'(mem_rd_en), W'(4'd0));
    chk("ill_no_wr", W'(mem_wr_en), W'(4'd0));
    chk("ill_tag_unissued", W'(mem_input_tag), W'(7'd3));
    finish_resp();
    chk("ill_done_ready", W'(req_ready), W'(1'b1));

    // Tag advanced past the illegal one; reset abandons the request mid-flight.
    req_rd_en = 4'b0001; req_wr_en = 4'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("post_ill_tag", W'(mem_input_tag), W'(7'd5));
    rst = 1'b0;
    tick();
    chk("midrst_ready", W'(req_ready), W'(1'b0));
    chk("midrst_rd_en", W'(mem_rd_en), W'(4'd0));
    chk("midrst_err", W'(err_tag_mismatch), W'(1'b0));
    chk("midrst_tag", W'(mem_input_tag), W'(7'd0));
    rst = 1'b1;
    tick();
    chk("midrst_release_ready", W'(req_ready), W'(1'b1));
    chk("midrst_no_resp", W'(resp_valid), W'(1'b0));

    // Back-to-back requests across the tag wrap.
    resp_ready = 1'b1;
    exp_tag = 7'd1;
    for (int i = 0; i < 128; i++) begin
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("wrap_issue_tag", W'(mem_input_tag), W'(exp_tag));
      tick();
      mem_ack = 1'b1; mem_output_tag = exp_tag;
      tick();
      mem_ack = 1'b0;
      chk("wrap_resp_tag", W'(resp_tag), W'(exp_tag));
      tick();
      exp_tag = (exp_tag == 7'd127) ? 7'd1 : exp_tag + 7'd1;
    end
    resp_ready = 1'b0;
    chk("wrap_next_tag_model", W'(exp_tag), W'(7'd2));
    chk("wrap_no_err", W'(err_tag_mismatch), W'(1'b0));

    // Stray ack in IDLE.
    mem_ack = 1'b1; mem_output_tag = 7'd2;
    tick();
    mem_ack = 1'b0;
    chk("idle_stray_ack", W'(err_tag_mismatch), W'(1'b1));

`ifdef MEM_INIT_TIMEOUT_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("to_waiting", W'(resp_valid), W'(1'b0));
    end
    tick();
    chk("to_resp_valid", W'(resp_valid), W'(1'b1));
    chk("to_resp_err", W'(resp_err), W'(1'b1));
    chk("to_resp_data", resp_data, W'(0));
    chk("to_resp_tag", W'(resp_tag), W'(7'd1));
    finish_resp();
    mem_ack = 1'b1; mem_output_tag = 7'd1;
    tick();
    mem_ack = 1'b0;
    chk("to_late_ack", W'(err_tag_mismatch), W'(1'b1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
